// File: rtl/ascon_ctrl_fsm_pkg.sv
// Shared ASCON controller definitions: state enum, default round counts and
// the Moore output decode used by the control FSM.
package ascon_pkg;

    localparam int ASCON_ROUNDS_A = 12;
    localparam int ASCON_ROUNDS_B = 6;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_PERM_INIT,
        S_KEY_INIT,
        S_AD_WAIT,
        S_PERM_AD,
        S_DOMSEP,
        S_DATA_WAIT,
        S_PERM_DATA,
        S_FINAL_WAIT,
        S_PERM_FINAL,
        S_TAG,
        S_DONE
    } ascon_ctrl_state_e;

    // Outputs that depend on the state alone (registered in the FSM)
    typedef struct packed {
        logic data_sel;
        logic en_reg_state;
        logic init_a;
        logic en_xor_key_end;
        logic en_xor_lsb;
        logic en_tag;
        logic data_ready;
        logic done;
        logic busy;
    } ascon_ctrl_moore_t;

    function automatic ascon_ctrl_moore_t ascon_ctrl_decode(input ascon_ctrl_state_e s);
        ascon_ctrl_moore_t m;
        m = '0;
        case (s)
            S_LOAD: begin
                m.data_sel     = 1'b1;
                m.en_reg_state = 1'b1;
                m.init_a       = 1'b1;
            end
            S_PERM_INIT, S_PERM_AD, S_PERM_DATA, S_PERM_FINAL: m.en_reg_state = 1'b1;
            S_KEY_INIT:  m.en_xor_key_end = 1'b1;
            S_DOMSEP:    m.en_xor_lsb = 1'b1;
            S_AD_WAIT, S_DATA_WAIT, S_FINAL_WAIT: m.data_ready = 1'b1;
            S_TAG: begin
                m.en_xor_key_end = 1'b1;
                m.en_tag         = 1'b1;
            end
            S_DONE:      m.done = 1'b1;
            default:     m = '0;
        endcase
        m.busy = (s != S_IDLE) && (s != S_DONE);
        return m;
    endfunction

endpackage

// File: rtl/ascon_round_counter.sv
// Round index counter for the permutation phases: synchronous load,
// count enable and a terminal-count flag against a run-time last value.
module ascon_round_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clock_i,
    input  logic             resetb_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] last_i,
    output logic [CNT_W-1:0] count_o,
    output logic             tc_o
);

    logic [CNT_W-1:0] r_count;

    // Load has priority over increment
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            r_count <= '0;
        end else if (load_i) begin
            r_count <= load_val_i;
        end else if (en_i) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count_o = r_count;
    assign tc_o    = (r_count == last_i);

endmodule

// File: rtl/ascon_ctrl_fsm.sv
// ASCON-128 control FSM: sequences init, AD, domain separation, PT/CT blocks,
// finalisation and tag over the shared state/XOR/permutation datapath.
module ascon_ctrl_fsm
    import ascon_pkg::*;
#(
    parameter int NB_AD_BLOCKS = 1,
    parameter int NB_PT_BLOCKS = 3,
    parameter int ROUNDS_A     = ASCON_ROUNDS_A,
    parameter int ROUNDS_B     = ASCON_ROUNDS_B,
    parameter int CNT_W        = 4
) (
    input  logic             clock_i,
    input  logic             resetb_i,
    input  logic             start_i,
    input  logic             decrypt_i,
    input  logic             data_valid_i,
    output logic             data_ready_o,
    output logic             decrypt_o,
    output logic             data_sel_o,
    output logic             en_reg_state_o,
    output logic             en_xor_key_o,
    output logic             en_xor_key_end_o,
    output logic             en_xor_lsb_o,
    output logic             en_xor_data_o,
    output logic             en_cipher_o,
    output logic             en_tag_o,
    output logic             init_a_o,
    output logic             init_b_o,
    output logic [CNT_W-1:0] round_o,
    output logic [CNT_W-1:0] block_o,
    output logic             cypher_valid_o,
    output logic             end_o,
    output logic             busy_o
);

    if (NB_AD_BLOCKS < 0 || NB_PT_BLOCKS < 1 || ROUNDS_A < 1 || ROUNDS_B < 1 ||
        ROUNDS_A >= (1 << CNT_W) || ROUNDS_B >= (1 << CNT_W) ||
        (NB_AD_BLOCKS + NB_PT_BLOCKS) >= (1 << CNT_W)) begin : g_bad_params
        $error("ascon_ctrl_fsm: illegal parameter combination");
    end

    localparam logic [CNT_W-1:0] LP_LAST_A   = CNT_W'(ROUNDS_A - 1);
    localparam logic [CNT_W-1:0] LP_LAST_B   = CNT_W'(ROUNDS_B - 1);
    localparam logic [CNT_W-1:0] LP_AD_END   = CNT_W'(NB_AD_BLOCKS);
    localparam logic [CNT_W-1:0] LP_DATA_END = CNT_W'(NB_AD_BLOCKS + NB_PT_BLOCKS - 1);

    ascon_ctrl_state_e  r_state;
    ascon_ctrl_state_e  w_state_nxt;
    ascon_ctrl_moore_t  r_moore;
    logic [CNT_W-1:0]   r_block;
    logic               r_decrypt;
    logic               r_cypher_valid;

    logic               w_start_acc;
    logic               w_acc_ad;
    logic               w_acc_data;
    logic               w_acc_final;
    logic               w_accept;
    logic               w_en_cipher;
    logic               w_in_perm;
    logic               w_round_tc;
    logic [CNT_W-1:0]   w_round;
    logic [CNT_W-1:0]   w_round_last;

    assign w_start_acc = start_i && (r_state == S_IDLE || r_state == S_DONE);
    assign w_acc_ad    = data_valid_i && (r_state == S_AD_WAIT);
    assign w_acc_data  = data_valid_i && (r_state == S_DATA_WAIT);
    assign w_acc_final = data_valid_i && (r_state == S_FINAL_WAIT);
    assign w_accept    = w_acc_ad || w_acc_data || w_acc_final;
    assign w_en_cipher = w_acc_data || w_acc_final;

    assign w_in_perm    = (r_state == S_PERM_INIT) || (r_state == S_PERM_AD) ||
                          (r_state == S_PERM_DATA) || (r_state == S_PERM_FINAL);
    assign w_round_last = (r_state == S_PERM_INIT || r_state == S_PERM_FINAL) ? LP_LAST_A : LP_LAST_B;

    // Round counter restarts from 0 on the last round so every PERM entry sees 0
    ascon_round_counter #(
        .CNT_W(CNT_W)
    ) u_round_cnt (
        .clock_i    (clock_i),
        .resetb_i   (resetb_i),
        .load_i     (w_in_perm && w_round_tc),
        .load_val_i ('0),
        .en_i       (w_in_perm && !w_round_tc),
        .last_i     (w_round_last),
        .count_o    (w_round),
        .tc_o       (w_round_tc)
    );

    // Next-state selection
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (start_i) w_state_nxt = S_LOAD;
            S_LOAD:         w_state_nxt = S_PERM_INIT;
            S_PERM_INIT:    if (w_round_tc) w_state_nxt = S_KEY_INIT;
            S_KEY_INIT:     w_state_nxt = (NB_AD_BLOCKS > 0) ? S_AD_WAIT : S_DOMSEP;
            S_AD_WAIT:      if (data_valid_i) w_state_nxt = S_PERM_AD;
            S_PERM_AD:      if (w_round_tc) w_state_nxt = (r_block < LP_AD_END) ? S_AD_WAIT : S_DOMSEP;
            S_DOMSEP:       w_state_nxt = (NB_PT_BLOCKS > 1) ? S_DATA_WAIT : S_FINAL_WAIT;
            S_DATA_WAIT:    if (data_valid_i) w_state_nxt = S_PERM_DATA;
            S_PERM_DATA:    if (w_round_tc) w_state_nxt = (r_block < LP_DATA_END) ? S_DATA_WAIT : S_FINAL_WAIT;
            S_FINAL_WAIT:   if (data_valid_i) w_state_nxt = S_PERM_FINAL;
            S_PERM_FINAL:   if (w_round_tc) w_state_nxt = S_TAG;
            S_TAG:          w_state_nxt = S_DONE;
            default:        w_state_nxt = S_IDLE;
        endcase
    end

    // State, registered Moore outputs (decoded from the next state so they align
    // with it), block counter, captured mode and the cipher-valid pulse
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            r_state        <= S_IDLE;
            r_moore        <= '0;
            r_block        <= '0;
            r_decrypt      <= 1'b0;
            r_cypher_valid <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_moore        <= ascon_ctrl_decode(w_state_nxt);
            r_cypher_valid <= w_en_cipher;
            if (w_start_acc) begin
                r_decrypt <= decrypt_i;
            end
            if (w_state_nxt == S_LOAD) begin
                r_block <= '0;
            end else if (w_accept) begin
                r_block <= r_block + CNT_W'(1);
            end
        end
    end

    assign data_ready_o     = r_moore.data_ready;
    assign decrypt_o        = r_decrypt;
    assign data_sel_o       = r_moore.data_sel;
    assign en_reg_state_o   = r_moore.en_reg_state | w_accept;
    assign en_xor_key_o     = w_acc_final;
    assign en_xor_key_end_o = r_moore.en_xor_key_end;
    assign en_xor_lsb_o     = r_moore.en_xor_lsb;
    assign en_xor_data_o    = w_accept;
    assign en_cipher_o      = w_en_cipher;
    assign en_tag_o         = r_moore.en_tag;
    assign init_a_o         = r_moore.init_a | w_acc_final;
    assign init_b_o         = w_acc_ad | w_acc_data;
    assign round_o          = w_round;
    assign block_o          = r_block;
    assign cypher_valid_o   = r_cypher_valid;
    assign end_o            = r_moore.done;
    assign busy_o           = r_moore.busy;

endmodule

// File: tb/tb_ascon_ctrl_fsm.sv
// Bench for ascon_ctrl_fsm: two instances (default config and NB_AD=0/NB_PT=1)
// share one stimulus; each is compared every cycle against a schedule model
// built from the operation's phase list, plus literal timing pins.
module tb_ascon_ctrl_fsm;

    localparam int RA = 12;
    localparam int RB = 6;
    localparam int CW = 4;

    localparam int K_IDLE = 0, K_LOAD = 1, K_PERM = 2, K_KEYI = 3, K_WAD = 4, K_DOMSEP = 5;
    localparam int K_WDAT = 6, K_WFIN = 7, K_TAG = 8, K_DONE = 9;

    logic clk = 1'b0;
    logic rstb, start, dec_in, valid;

    logic [1:0] rdy, sel, ereg, xkey, xkend, lsb, xdat, ciph, tag, ia, ib, cvld, endo, busy, deco;
    logic [CW-1:0] rnd [2];
    logic [CW-1:0] blk [2];

    always #5 clk = ~clk;

    ascon_ctrl_fsm u_dut0 (
        .clock_i(clk), .resetb_i(rstb), .start_i(start), .decrypt_i(dec_in), .data_valid_i(valid),
        .data_ready_o(rdy[0]), .decrypt_o(deco[0]), .data_sel_o(sel[0]), .en_reg_state_o(ereg[0]),
        .en_xor_key_o(xkey[0]), .en_xor_key_end_o(xkend[0]), .en_xor_lsb_o(lsb[0]),
        .en_xor_data_o(xdat[0]), .en_cipher_o(ciph[0]), .en_tag_o(tag[0]), .init_a_o(ia[0]),
        .init_b_o(ib[0]), .round_o(rnd[0]), .block_o(blk[0]), .cypher_valid_o(cvld[0]),
        .end_o(endo[0]), .busy_o(busy[0])
    );

    ascon_ctrl_fsm #(.NB_AD_BLOCKS(0), .NB_PT_BLOCKS(1)) u_dut1 (
        .clock_i(clk), .resetb_i(rstb), .start_i(start), .decrypt_i(dec_in), .data_valid_i(valid),
        .data_ready_o(rdy[1]), .decrypt_o(deco[1]), .data_sel_o(sel[1]), .en_reg_state_o(ereg[1]),
        .en_xor_key_o(xkey[1]), .en_xor_key_end_o(xkend[1]), .en_xor_lsb_o(lsb[1]),
        .en_xor_data_o(xdat[1]), .en_cipher_o(ciph[1]), .en_tag_o(tag[1]), .init_a_o(ia[1]),
        .init_b_o(ib[1]), .round_o(rnd[1]), .block_o(blk[1]), .cypher_valid_o(cvld[1]),
        .end_o(endo[1]), .busy_o(busy[1])
    );

    int   NAD [2] = '{1, 0};
    int   NPT [2] = '{3, 1};
    int   pos [2] = '{-1, -1};
    int   blocks [2] = '{0, 0};
    logic mdec [2] = '{1'b0, 1'b0};
    logic mcv  [2] = '{1'b0, 1'b0};

    int tests = 0;
    int fails = 0;
    int cyc, end0, end1, stall_rdy;
    int cvq [$];
    logic s_end, s_sel;
    int   s_blk;
    logic s_dec;

    // Position k of an operation mapped to its phase: LOAD, p^a, KEY, AD blocks,
    // DOMSEP, non-final data blocks, final block, p^a, TAG, then DONE.
    function automatic void step_at(input int nad, input int npt, input int k_in,
                                    output int kind, output int r);
        int k;
        k = k_in;
        kind = K_DONE;
        r = 0;
        if (k < 0) begin kind = K_IDLE; return; end
        if (k == 0) begin kind = K_LOAD; return; end
        k -= 1;
        if (k < RA) begin kind = K_PERM; r = k; return; end
        k -= RA;
        if (k == 0) begin kind = K_KEYI; return; end
        k -= 1;
        if (k < nad * (RB + 1)) begin
            if (k % (RB + 1) == 0) kind = K_WAD;
            else begin kind = K_PERM; r = k % (RB + 1) - 1; end
            return;
        end
        k -= nad * (RB + 1);
        if (k == 0) begin kind = K_DOMSEP; return; end
        k -= 1;
        if (k < (npt - 1) * (RB + 1)) begin
            if (k % (RB + 1) == 0) kind = K_WDAT;
            else begin kind = K_PERM; r = k % (RB + 1) - 1; end
            return;
        end
        k -= (npt - 1) * (RB + 1);
        if (k == 0) begin kind = K_WFIN; return; end
        k -= 1;
        if (k < RA) begin kind = K_PERM; r = k; return; end
        k -= RA;
        if (k == 0) kind = K_TAG;
    endfunction

    // Order: rdy,sel,reg,key,kend,lsb,xdata,cipher,tag,init_a,init_b,cvalid,end,busy,dec
    function automatic logic [14:0] exp_vec(input int kind, input logic v, input int i);
        logic r_, s_, e_, k_, ke, l_, xd, c_, t_, ia_, ib_, en_, b_;
        {r_, s_, e_, k_, ke, l_, xd, c_, t_, ia_, ib_, en_} = '0;
        case (kind)
            K_LOAD:   begin s_ = 1'b1; e_ = 1'b1; ia_ = 1'b1; end
            K_PERM:   e_ = 1'b1;
            K_KEYI:   ke = 1'b1;
            K_DOMSEP: l_ = 1'b1;
            K_TAG:    begin ke = 1'b1; t_ = 1'b1; end
            K_DONE:   en_ = 1'b1;
            K_WAD:    begin r_ = 1'b1; xd = v; e_ = v; ib_ = v; end
            K_WDAT:   begin r_ = 1'b1; xd = v; e_ = v; ib_ = v; c_ = v; end
            K_WFIN:   begin r_ = 1'b1; xd = v; e_ = v; c_ = v; k_ = v; ia_ = v; end
            default:  ;
        endcase
        b_ = (kind != K_IDLE) && (kind != K_DONE);
        return {r_, s_, e_, k_, ke, l_, xd, c_, t_, ia_, ib_, mcv[i], en_, b_, mdec[i]};
    endfunction

    function automatic logic [14:0] act_vec(input int i);
        return {rdy[i], sel[i], ereg[i], xkey[i], xkend[i], lsb[i], xdat[i], ciph[i], tag[i],
                ia[i], ib[i], cvld[i], endo[i], busy[i], deco[i]};
    endfunction

    task automatic chk(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    task automatic check_cycle();
        int kind, r;
        logic [14:0] ev, av;
        for (int i = 0; i < 2; i++) begin
            step_at(NAD[i], NPT[i], pos[i], kind, r);
            ev = exp_vec(kind, valid, i);
            av = act_vec(i);
            tests++;
            if (av !== ev || rnd[i] !== CW'(r) || blk[i] !== CW'(blocks[i])) begin
                fails++;
                $display("FAIL cycle_check inst%0d cyc %0d: outputs %b (required %b) round %0d (required %0d) block %0d (required %0d)",
                         i, cyc, av, ev, rnd[i], r, blk[i], blocks[i]);
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            pos[i] = -1; blocks[i] = 0; mdec[i] = 1'b0; mcv[i] = 1'b0;
        end
    endtask

    task automatic advance();
        int kind, r;
        if (!rstb) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 2; i++) begin
            step_at(NAD[i], NPT[i], pos[i], kind, r);
            mcv[i] = valid && (kind == K_WDAT || kind == K_WFIN);
            case (kind)
                K_IDLE, K_DONE: if (start) begin pos[i] = 0; blocks[i] = 0; mdec[i] = dec_in; end
                K_WAD, K_WDAT, K_WFIN: if (valid) begin pos[i]++; blocks[i]++; end
                default: pos[i]++;
            endcase
        end
    endtask

    // One clock: check at the falling edge, step the model, return 1 after the rising edge
    task automatic tick();
        @(negedge clk);
        check_cycle();
        s_end = endo[0]; s_blk = int'(blk[0]); s_sel = sel[0]; s_dec = deco[0];
        if (endo[0] && end0 < 0) end0 = cyc;
        if (endo[1] && end1 < 0) end1 = cyc;
        if (cvld[0]) cvq.push_back(cyc);
        if (rdy[0] && !valid) stall_rdy++;
        advance();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic begin_test();
        cyc = -1; end0 = -1; end1 = -1; stall_rdy = 0;
        cvq.delete();
    endtask

    initial begin
        rstb = 1'b0; start = 1'b0; valid = 1'b0; dec_in = 1'b0;
        begin_test();
        tick();
        tick();
        chk("reset outputs inst0", int'(act_vec(0)), 0);
        chk("reset outputs inst1", int'(act_vec(1)), 0);
        chk("reset round", int'(rnd[0]), 0);
        rstb = 1'b1;
        tick();

        // Nominal run, data_valid tied high
        begin_test();
        valid = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (60) tick();
        chk("end_o edge default", end0, 50);
        chk("end_o edge no-AD single-PT", end1, 29);
        chk("cypher_valid pulse count", cvq.size(), 3);
        // high during cycles 23/30/37, i.e. seen by sampling edges 24/31/38
        if (cvq.size() == 3) begin
            chk("cypher_valid pulse 1", cvq[0], 23);
            chk("cypher_valid pulse 2", cvq[1], 30);
            chk("cypher_valid pulse 3", cvq[2], 37);
        end

        // Stall 7 cycles at the second data block, decrypt toggled mid-run
        begin_test();
        start = 1'b1; dec_in = 1'b1;
        tick();
        start = 1'b0;
        while (cyc <= 70) begin
            valid = !(cyc >= 29 && cyc <= 35);
            if (cyc == 10 || cyc == 20 || cyc == 40) dec_in = ~dec_in;
            tick();
        end
        chk("stalled ready cycles", stall_rdy, 7);
        chk("end_o edge with stall", end0, 57);
        chk("decrypt_o held", int'(s_dec), 1);

        // Asynchronous reset in PERM_DATA round 3, then a normal restart
        begin_test();
        valid = 1'b1; start = 1'b1; dec_in = 1'b1;
        tick();
        start = 1'b0;
        while (cyc < 26) tick();
        chk("round before reset", int'(rnd[0]), 3);
        #2 rstb = 1'b0;
        #1;
        chk("async reset outputs inst0", int'(act_vec(0)), 0);
        chk("async reset outputs inst1", int'(act_vec(1)), 0);
        chk("async reset round", int'(rnd[0]), 0);
        chk("async reset block", int'(blk[0]), 0);
        model_reset();
        @(posedge clk);
        #1;
        rstb = 1'b1;
        begin_test();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (55) tick();
        chk("end_o edge after restart", end0, 50);

        // start held high across DONE restarts on the next edge
        begin_test();
        start = 1'b1; dec_in = 1'b0;
        tick();
        while (cyc <= 53) begin
            tick();
            if (cyc == 51) chk("held start: end_o at DONE", int'(s_end), 1);
            if (cyc == 52) begin
                chk("held start: end_o after restart", int'(s_end), 0);
                chk("held start: block_o after restart", s_blk, 0);
                chk("held start: data_sel after restart", int'(s_sel), 1);
            end
        end
        start = 1'b0;

        // Randomised traffic: stalls, random start timing, mode flips, rare resets
        begin_test();
        for (int n = 0; n < 4000; n++) begin
            valid  = ($urandom_range(0, 99) < 70);
            start  = ($urandom_range(0, 19) == 0);
            dec_in = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 599) == 0) begin
                rstb = 1'b0;
                model_reset();
                tick();
                rstb = 1'b1;
            end else begin
                tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
